// File: rtl/qed_pkg.sv
// Shared types and constants for the SQED consistency checker.
package qed_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int unsigned DUP_OFFSET = 16;
    localparam int unsigned NUM_REGS   = 32;
    localparam int unsigned REG_AW     = $clog2(NUM_REGS);
    localparam int unsigned IDX_W      = 4;

endpackage

// File: rtl/qed_shadow_rf.sv
// Shadow copy of the architectural register file: one write port, two
// combinational read ports for the original/duplicate pair under test.
module qed_shadow_rf
    import qed_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [REG_AW-1:0] waddr,
    input  logic [31:0]       wdata,
    input  logic [REG_AW-1:0] raddr_a,
    output logic [31:0]       rdata_a,
    input  logic [REG_AW-1:0] raddr_b,
    output logic [31:0]       rdata_b
);

    logic [31:0] regs_q [NUM_REGS];
    logic [31:0] regs_d [NUM_REGS];

    always_comb begin
        regs_d = regs_q;
        // r0 is hardwired to zero, so its shadow never takes a write
        if (we && (waddr != '0)) begin
            regs_d[waddr] = wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            regs_q <= '{default: '0};
        end else begin
            regs_q <= regs_d;
        end
    end

    assign rdata_a = regs_q[raddr_a];
    assign rdata_b = regs_q[raddr_b];

endmodule

// File: rtl/qed_consistency_check.sv
// Counts committed original/duplicate instructions and, once they balance,
// scans the shadow register file for original/duplicate pair mismatches.
module qed_consistency_check
    import qed_pkg::*;
#(
    parameter int unsigned CNT_W     = 16,
    parameter int unsigned NUM_PAIRS = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ena,
    input  logic              wb_vld,
    input  logic              wb_dup,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic [31:0]       wb_data,
    input  logic              commit_vld,
    input  logic              commit_dup,
    output logic              qed_ready,
    output logic              check_busy,
    output logic              check_done,
    output logic              check_fail,
    output logic [IDX_W-1:0]  fail_idx,
    output logic              cnt_ovf
);

    localparam logic [CNT_W-1:0] CntMax  = '1;
    localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);
    localparam logic [IDX_W-1:0] LastIdx = IDX_W'(NUM_PAIRS);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]   orig_cnt_q, orig_cnt_d;
    logic [CNT_W-1:0]   dup_cnt_q, dup_cnt_d;
    logic               cnt_ovf_q, cnt_ovf_d;
    logic               qed_ready_q, qed_ready_d;
    logic               ready_prev_q;
    logic               check_fail_q, check_fail_d;
    logic [IDX_W-1:0]   fail_idx_q, fail_idx_d;

    logic [REG_AW-1:0]  rd_orig_addr, rd_dup_addr;
    logic [31:0]        rd_orig_data, rd_dup_data;
    logic               shadow_we;

    // The writeback tag is carried for visibility only; the register index
    // already distinguishes original from duplicate destinations.
    logic unused_wb_dup;
    assign unused_wb_dup = wb_dup;

    assign shadow_we    = wb_vld && ena;
    assign rd_orig_addr = REG_AW'(idx_q);
    assign rd_dup_addr  = rd_orig_addr + REG_AW'(DUP_OFFSET);

    qed_shadow_rf u_shadow_rf (
        .clk     (clk),
        .rst     (rst),
        .we      (shadow_we),
        .waddr   (wb_rd),
        .wdata   (wb_data),
        .raddr_a (rd_orig_addr),
        .rdata_a (rd_orig_data),
        .raddr_b (rd_dup_addr),
        .rdata_b (rd_dup_data)
    );

    always_comb begin
        orig_cnt_d = orig_cnt_q;
        dup_cnt_d  = dup_cnt_q;
        cnt_ovf_d  = cnt_ovf_q;
        if (commit_vld && ena) begin
            if (commit_dup) begin
                if (dup_cnt_q == CntMax) cnt_ovf_d = 1'b1;
                else                     dup_cnt_d = dup_cnt_q + CntOne;
            end else begin
                if (orig_cnt_q == CntMax) cnt_ovf_d  = 1'b1;
                else                      orig_cnt_d = orig_cnt_q + CntOne;
            end
        end
        qed_ready_d = (orig_cnt_q == dup_cnt_q) && (orig_cnt_q != '0) && !cnt_ovf_q;
    end

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        check_fail_d = check_fail_q;
        fail_idx_d   = fail_idx_q;
        unique case (state_q)
            IDLE: begin
                if (ena && qed_ready_q && !ready_prev_q) begin
                    state_d = SCAN;
                    idx_d   = IDX_W'(1);
                end
            end
            SCAN: begin
                if (!ena) begin
                    state_d = IDLE;
                end else begin
                    // Only the first mismatch is recorded
                    if ((rd_orig_data != rd_dup_data) && !check_fail_q) begin
                        check_fail_d = 1'b1;
                        fail_idx_d   = idx_q;
                    end
                    if (idx_q == LastIdx) state_d = DONE;
                    else                  idx_d   = idx_q + IDX_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            orig_cnt_q   <= '0;
            dup_cnt_q    <= '0;
            cnt_ovf_q    <= 1'b0;
            qed_ready_q  <= 1'b0;
            ready_prev_q <= 1'b0;
            check_fail_q <= 1'b0;
            fail_idx_q   <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            orig_cnt_q   <= orig_cnt_d;
            dup_cnt_q    <= dup_cnt_d;
            cnt_ovf_q    <= cnt_ovf_d;
            qed_ready_q  <= qed_ready_d;
            ready_prev_q <= qed_ready_q;
            check_fail_q <= check_fail_d;
            fail_idx_q   <= fail_idx_d;
        end
    end

    assign qed_ready  = qed_ready_q;
    assign check_busy = (state_q == SCAN);
    assign check_done = (state_q == DONE);
    assign check_fail = check_fail_q;
    assign fail_idx   = fail_idx_q;
    assign cnt_ovf    = cnt_ovf_q;

endmodule

// File: tb/tb_qed_consistency_check.sv
// Directed bench for qed_consistency_check, built with 4-bit commit counters so
// saturation is reachable in a few cycles.
module tb_qed_consistency_check;

    logic        clk = 1'b0;
    logic        rst;
    logic        ena;
    logic        wb_vld;
    logic        wb_dup;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        commit_vld;
    logic        commit_dup;
    logic        qed_ready;
    logic        check_busy;
    logic        check_done;
    logic        check_fail;
    logic [3:0]  fail_idx;
    logic        cnt_ovf;

    int n_checks = 0;
    int n_fails  = 0;

    qed_consistency_check #(
        .CNT_W     (4),
        .NUM_PAIRS (15)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ena        (ena),
        .wb_vld     (wb_vld),
        .wb_dup     (wb_dup),
        .wb_rd      (wb_rd),
        .wb_data    (wb_data),
        .commit_vld (commit_vld),
        .commit_dup (commit_dup),
        .qed_ready  (qed_ready),
        .check_busy (check_busy),
        .check_done (check_done),
        .check_fail (check_fail),
        .fail_idx   (fail_idx),
        .cnt_ovf    (cnt_ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        wb_vld = 1'b0; wb_dup = 1'b0; wb_rd = '0; wb_data = '0;
        commit_vld = 1'b0; commit_dup = 1'b0;
    endtask

    task automatic wb_commit(input logic [4:0] rd, input logic [31:0] d,
                             input logic do_commit, input logic dup);
        wb_vld = 1'b1; wb_rd = rd; wb_data = d; wb_dup = dup;
        commit_vld = do_commit; commit_dup = dup;
        step();
        clear_in();
    endtask

    task automatic commit(input logic dup);
        commit_vld = 1'b1; commit_dup = dup;
        step();
        clear_in();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk(tag, {23'b0, qed_ready, check_busy, check_done, check_fail, cnt_ovf, fail_idx}, 32'h0);
    endtask

    // Called right after the balancing duplicate commit has been sampled.
    task automatic arm(input string tag);
        step();
        chk({tag, "_ready"}, qed_ready, 1'b1);
        chk({tag, "_busy_pre"}, check_busy, 1'b0);
        step();
        chk({tag, "_busy"}, check_busy, 1'b1);
    endtask

    task automatic run_to_done(input string tag, input int exp_steps,
                               input logic exp_fail, input logic [3:0] exp_idx);
        int n = 0;
        while (!check_done && n < 40) begin
            step();
            n++;
        end
        chk({tag, "_len"}, n, exp_steps);
        chk({tag, "_done"}, check_done, 1'b1);
        chk({tag, "_busy_end"}, check_busy, 1'b0);
        chk({tag, "_fail"}, check_fail, exp_fail);
        chk({tag, "_fidx"}, fail_idx, exp_idx);
        step();
        chk({tag, "_done_pulse"}, check_done, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach the end");
        $fatal(1, "timeout");
    end

    initial begin
        clear_in();
        ena = 1'b1;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        chk_all_zero("reset");

        // Matching pair r3/r19
        wb_commit(5'd3, 32'h0000_1234, 1'b1, 1'b0);
        wb_commit(5'd19, 32'h0000_1234, 1'b1, 1'b1);
        chk("match_ready_lat", qed_ready, 1'b0);
        arm("match");
        run_to_done("match", 15, 1'b0, 4'd0);

        // Mismatch at pair 5, then a later mismatch at pair 2
        do_reset();
        wb_commit(5'd5, 32'hDEAD_BEEF, 1'b1, 1'b0);
        wb_commit(5'd21, 32'hDEAD_BEEE, 1'b1, 1'b1);
        arm("mis");
        repeat (4) step();
        chk("mis_fail_pre", check_fail, 1'b0);
        step();
        chk("mis_fail", check_fail, 1'b1);
        chk("mis_fidx", fail_idx, 4'd5);
        run_to_done("mis", 10, 1'b1, 4'd5);
        wb_commit(5'd2, 32'h1, 1'b0, 1'b0);
        wb_commit(5'd18, 32'h2, 1'b0, 1'b1);
        commit(1'b0);
        commit(1'b1);
        arm("mis2");
        run_to_done("mis2", 15, 1'b1, 4'd5);

        // Imbalance, then abort by ena mid-scan
        do_reset();
        repeat (3) commit(1'b0);
        repeat (2) commit(1'b1);
        repeat (3) step();
        chk("imb_ready", qed_ready, 1'b0);
        chk("imb_busy", check_busy, 1'b0);
        commit(1'b1);
        arm("imb");
        repeat (3) step();
        ena = 1'b0;
        step();
        chk("abort_busy", check_busy, 1'b0);
        chk("abort_done", check_done, 1'b0);
        commit(1'b0);
        step();
        step();
        chk("abort_done2", check_done, 1'b0);
        chk("abort_cnt_hold", qed_ready, 1'b1);
        ena = 1'b1;
        step();
        step();
        chk("abort_no_rescan", check_busy, 1'b0);

        // Saturation of the 4-bit counters
        do_reset();
        repeat (16) commit(1'b0);
        step();
        chk("sat_ovf", cnt_ovf, 1'b1);
        chk("sat_ready", qed_ready, 1'b0);
        repeat (15) commit(1'b1);
        repeat (3) step();
        chk("sat_ready_bal", qed_ready, 1'b0);
        chk("sat_busy", check_busy, 1'b0);
        chk("sat_ovf_sticky", cnt_ovf, 1'b1);

        // Reset during a scan clears outputs and shadow
        do_reset();
        wb_commit(5'd7, 32'h0000_AAAA, 1'b1, 1'b0);
        wb_commit(5'd23, 32'h0000_5555, 1'b1, 1'b1);
        arm("rst");
        repeat (7) step();
        chk("rst_fail_pre", check_fail, 1'b1);
        chk("rst_fidx_pre", fail_idx, 4'd7);
        chk("rst_busy_pre", check_busy, 1'b1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_all_zero("rst_mid_scan");
        commit(1'b0);
        commit(1'b1);
        arm("rst_clr");
        run_to_done("rst_clr", 15, 1'b0, 4'd0);

        // r0 write ignored; write to r17 during pair 1 compare uses old value
        do_reset();
        wb_commit(5'd0, 32'hFFFF_FFFF, 1'b0, 1'b0);
        chk("r0_zero", dut.u_shadow_rf.regs_q[0], 32'h0);
        wb_commit(5'd1, 32'h11, 1'b1, 1'b0);
        wb_commit(5'd17, 32'h11, 1'b1, 1'b1);
        arm("same");
        wb_commit(5'd17, 32'h22, 1'b0, 1'b1);
        chk("same_fail", check_fail, 1'b0);
        run_to_done("same", 14, 1'b0, 4'd0);
        commit(1'b0);
        commit(1'b1);
        arm("same2");
        run_to_done("same2", 15, 1'b1, 4'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
